// File: rtl/mc_ctrl_unit.sv
// Multicycle control decoder: single-cycle decode plus MUL/DIV start/wait/writeback sequencing.
// Optional MD_TIMEOUT_EN aborts a MUL/DIV that stays in MD_WAIT for MD_TIMEOUT cycles.
module mc_ctrl_unit #(
  parameter int REGW       = 5,
  parameter int STATUS_REG = 30,
  parameter int RA_REG     = 31,
  parameter int MD_TIMEOUT = 40
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            instr_valid,
  input  logic [4:0]      opcode,
  input  logic [4:0]      aluop,
  input  logic            overflow,
  input  logic            md_ready,
  input  logic            md_exception,
  output logic            stall,
  output logic            md_start,
  output logic            md_op,
  output logic            rwe,
  output logic [1:0]      rwd_sel,
  output logic            rd_override_en,
  output logic [REGW-1:0] rd_override,
  output logic [31:0]     status_val,
  output logic            dmwe,
  output logic            alu_inb,
  output logic [4:0]      alu_opctrl
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [REGW-1:0] STATUS_IDX = REGW'(STATUS_REG);
  localparam logic [REGW-1:0] RA_IDX     = REGW'(RA_REG);

  typedef enum logic [1:0] {IDLE, MD_WAIT, MD_WB} state_t;

  state_t state;
  logic   md_op_q;
  logic   exc_q;
  logic   to_q;
  logic   is_md;

  assign is_md = instr_valid && (opcode == OP_RTYPE) &&
                 ((aluop == ALU_MUL) || (aluop == ALU_DIV));

`ifdef MD_TIMEOUT_EN
  localparam int CW = $clog2(MD_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(MD_TIMEOUT - 1);
  logic [CW-1:0] to_cnt;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      md_op_q <= 1'b0;
      exc_q   <= 1'b0;
      to_q    <= 1'b0;
`ifdef MD_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            state   <= MD_WAIT;
            md_op_q <= aluop[0];
            exc_q   <= 1'b0;
            to_q    <= 1'b0;
`ifdef MD_TIMEOUT_EN
            to_cnt  <= '0;
`endif
          end
        end
        MD_WAIT: begin
          // md_ready takes priority over an expiring timeout in the same cycle
          if (md_ready) begin
            exc_q <= md_exception;
            state <= MD_WB;
`ifdef MD_TIMEOUT_EN
          end else if (to_cnt == TO_LAST) begin
            exc_q <= 1'b1;
            to_q  <= 1'b1;
            state <= MD_WB;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        MD_WB:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall          = 1'b0;
    md_start       = 1'b0;
    md_op          = 1'b0;
    rwe            = 1'b0;
    rwd_sel        = 2'd0;
    rd_override_en = 1'b0;
    rd_override    = '0;
    status_val     = 32'd0;
    dmwe           = 1'b0;
    alu_inb        = 1'b0;
    alu_opctrl     = 5'd0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          case (opcode)
            OP_RTYPE: begin
              alu_opctrl = aluop;
              if (is_md) begin
                stall    = 1'b1;
                md_start = 1'b1;
                md_op    = aluop[0];
              end else begin
                rwe = 1'b1;
                if (overflow && (aluop == ALU_ADD || aluop == ALU_SUB)) begin
                  rwd_sel        = 2'd3;
                  rd_override_en = 1'b1;
                  rd_override    = STATUS_IDX;
                  status_val     = (aluop == ALU_ADD) ? 32'd1 : 32'd3;
                end
              end
            end
            OP_ADDI: begin
              rwe     = 1'b1;
              alu_inb = 1'b1;
              if (overflow) begin
                rwd_sel        = 2'd3;
                rd_override_en = 1'b1;
                rd_override    = STATUS_IDX;
                status_val     = 32'd2;
              end
            end
            OP_SW: begin
              dmwe    = 1'b1;
              alu_inb = 1'b1;
            end
            OP_LW: begin
              rwe     = 1'b1;
              rwd_sel = 2'd1;
              alu_inb = 1'b1;
            end
            OP_JAL: begin
              rwe            = 1'b1;
              rwd_sel        = 2'd3;
              rd_override_en = 1'b1;
              rd_override    = RA_IDX;
            end
            OP_SETX: begin
              rwe            = 1'b1;
              rwd_sel        = 2'd3;
              rd_override_en = 1'b1;
              rd_override    = STATUS_IDX;
            end
            default: ;
          endcase
        end
      end
      MD_WAIT: begin
        stall = 1'b1;
        md_op = md_op_q;
      end
      MD_WB: begin
        md_op = md_op_q;
        rwe   = 1'b1;
        if (exc_q) begin
          rwd_sel        = 2'd3;
          rd_override_en = 1'b1;
          rd_override    = STATUS_IDX;
          status_val     = to_q ? 32'd6 : (md_op_q ? 32'd5 : 32'd4);
        end else begin
          rwd_sel = 2'd2;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Bench for mc_ctrl_unit: per-cycle expected control vectors queued at drive time, compared mid-cycle.
module tb_mc_ctrl_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [4:0]  opcode;
  logic [4:0]  aluop;
  logic        overflow;
  logic        md_ready;
  logic        md_exception;
  logic        stall;
  logic        md_start;
  logic        md_op;
  logic        rwe;
  logic [1:0]  rwd_sel;
  logic        rd_override_en;
  logic [4:0]  rd_override;
  logic [31:0] status_val;
  logic        dmwe;
  logic        alu_inb;
  logic [4:0]  alu_opctrl;

  int total = 0;
  int bad   = 0;
  logic [50:0] sb[$];

  always #5 clock = ~clock;

  mc_ctrl_unit #(.REGW(5), .STATUS_REG(30), .RA_REG(31), .MD_TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .opcode(opcode),
    .aluop(aluop), .overflow(overflow), .md_ready(md_ready), .md_exception(md_exception),
    .stall(stall), .md_start(md_start), .md_op(md_op), .rwe(rwe), .rwd_sel(rwd_sel),
    .rd_override_en(rd_override_en), .rd_override(rd_override), .status_val(status_val),
    .dmwe(dmwe), .alu_inb(alu_inb), .alu_opctrl(alu_opctrl)
  );

  function automatic logic [50:0] ev(input logic st, input logic sa, input logic mo,
                                     input logic we, input logic [1:0] sel, input logic oen,
                                     input logic [4:0] od, input logic [31:0] sv,
                                     input logic dm, input logic inb, input logic [4:0] opc);
    return {st, sa, mo, we, sel, oen, od, sv, dm, inb, opc};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
  task automatic step(input string tag, input logic v, input logic [4:0] op, input logic [4:0] ao,
                      input logic ov, input logic rdy, input logic exc, input logic [50:0] e);
    logic [50:0] exp_v;
    instr_valid  = v;
    opcode       = op;
    aluop        = ao;
    overflow     = ov;
    md_ready     = rdy;
    md_exception = exc;
    sb.push_back(e);
    @(negedge clock);
    exp_v = sb.pop_front();
    check_val(tag, 64'({stall, md_start, md_op, rwe, rwd_sel, rd_override_en, rd_override,
                        status_val, dmwe, alu_inb, alu_opctrl}), 64'(exp_v));
    @(posedge clock);
    #1;
  endtask

  localparam logic [50:0] Z = 51'd0;

  initial begin
    reset_n = 1'b0;
    instr_valid = 1'b0; opcode = 5'd0; aluop = 5'd0;
    overflow = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
    step("reset", 0, 5'd0, 5'd0, 0, 0, 0, Z);
    reset_n = 1'b1;
    step("idle", 0, 5'd0, 5'd0, 0, 0, 0, Z);
    step("idle_rdy", 0, 5'd0, 5'd0, 0, 1, 1, Z);
    step("idle_after_rdy", 0, 5'd0, 5'd0, 0, 0, 0, Z);

    // Single-cycle decode
    step("add", 1, 5'd0, 5'd0, 0, 0, 0, ev(0,0,0,1,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("add_ovf", 1, 5'd0, 5'd0, 1, 0, 0, ev(0,0,0,1,2'd3,1,5'd30,32'd1,0,0,5'd0));
    step("addi_ovf", 1, 5'd5, 5'd0, 1, 0, 0, ev(0,0,0,1,2'd3,1,5'd30,32'd2,0,1,5'd0));
    step("sub_ovf", 1, 5'd0, 5'd1, 1, 0, 0, ev(0,0,0,1,2'd3,1,5'd30,32'd3,0,0,5'd1));
    step("sub", 1, 5'd0, 5'd1, 0, 0, 0, ev(0,0,0,1,2'd0,0,5'd0,32'd0,0,0,5'd1));
    step("and", 1, 5'd0, 5'd2, 0, 0, 0, ev(0,0,0,1,2'd0,0,5'd0,32'd0,0,0,5'd2));
    step("addi", 1, 5'd5, 5'd9, 0, 0, 0, ev(0,0,0,1,2'd0,0,5'd0,32'd0,0,1,5'd0));
    step("lw", 1, 5'd8, 5'd0, 0, 0, 0, ev(0,0,0,1,2'd1,0,5'd0,32'd0,0,1,5'd0));
    step("sw", 1, 5'd7, 5'd0, 0, 0, 0, ev(0,0,0,0,2'd0,0,5'd0,32'd0,1,1,5'd0));
    step("jal", 1, 5'd3, 5'd0, 0, 0, 0, ev(0,0,0,1,2'd3,1,5'd31,32'd0,0,0,5'd0));
    step("setx", 1, 5'd21, 5'd0, 0, 0, 0, ev(0,0,0,1,2'd3,1,5'd30,32'd0,0,0,5'd0));
    step("bne", 1, 5'd2, 5'd0, 1, 0, 0, Z);
    step("invalid_add", 0, 5'd0, 5'd0, 1, 0, 0, Z);

    // mul with md_ready on the 5th wait cycle: 1 start + 5 wait + 1 writeback
    step("mul_start", 1, 5'd0, 5'd6, 0, 0, 0, ev(1,1,0,0,2'd0,0,5'd0,32'd0,0,0,5'd6));
    for (int i = 0; i < 4; i++)
      step("mul_wait", 1, 5'd0, 5'd6, 0, 0, 0, ev(1,0,0,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("mul_wait_rdy", 1, 5'd0, 5'd6, 0, 1, 0, ev(1,0,0,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("mul_wb", 0, 5'd0, 5'd0, 0, 0, 0, ev(0,0,0,1,2'd2,0,5'd0,32'd0,0,0,5'd0));
    step("after_mul", 0, 5'd0, 5'd0, 0, 0, 0, Z);

    // div with exception; instr_valid dropping mid-wait has no effect
    step("div_start", 1, 5'd0, 5'd7, 0, 0, 0, ev(1,1,1,0,2'd0,0,5'd0,32'd0,0,0,5'd7));
    step("div_wait", 0, 5'd0, 5'd0, 0, 0, 0, ev(1,0,1,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("div_wait_iv", 1, 5'd8, 5'd0, 0, 0, 0, ev(1,0,1,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("div_rdy_exc", 1, 5'd0, 5'd7, 0, 1, 1, ev(1,0,1,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("div_wb_exc", 0, 5'd0, 5'd0, 0, 0, 0, ev(0,0,1,1,2'd3,1,5'd30,32'd5,0,0,5'd0));

    // mul with exception, then back-to-back mul presented during writeback
    step("mul2_start", 1, 5'd0, 5'd6, 0, 0, 0, ev(1,1,0,0,2'd0,0,5'd0,32'd0,0,0,5'd6));
    step("mul2_rdy_exc", 1, 5'd0, 5'd6, 0, 1, 1, ev(1,0,0,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("mul2_wb_b2b", 1, 5'd0, 5'd6, 0, 1, 0, ev(0,0,0,1,2'd3,1,5'd30,32'd4,0,0,5'd0));
    step("mul3_start", 1, 5'd0, 5'd6, 0, 0, 0, ev(1,1,0,0,2'd0,0,5'd0,32'd0,0,0,5'd6));
    step("mul3_rdy", 1, 5'd0, 5'd6, 0, 1, 0, ev(1,0,0,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("mul3_wb", 0, 5'd0, 5'd0, 0, 0, 0, ev(0,0,0,1,2'd2,0,5'd0,32'd0,0,0,5'd0));

    // Reset while waiting aborts without a write
    step("rst_start", 1, 5'd0, 5'd7, 0, 0, 0, ev(1,1,1,0,2'd0,0,5'd0,32'd0,0,0,5'd7));
    step("rst_wait", 1, 5'd0, 5'd7, 0, 0, 0, ev(1,0,1,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    reset_n = 1'b0;
    step("rst_mid_wait", 0, 5'd0, 5'd0, 0, 0, 0, Z);
    reset_n = 1'b1;
    step("rst_late_rdy", 0, 5'd0, 5'd0, 0, 1, 0, Z);
    step("rst_after", 0, 5'd0, 5'd0, 0, 0, 0, Z);

`ifdef MD_TIMEOUT_EN
    step("to_start", 1, 5'd0, 5'd6, 0, 0, 0, ev(1,1,0,0,2'd0,0,5'd0,32'd0,0,0,5'd6));
    for (int i = 0; i < 4; i++)
      step("to_wait", 1, 5'd0, 5'd6, 0, 0, 0, ev(1,0,0,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("to_wb", 0, 5'd0, 5'd0, 0, 0, 0, ev(0,0,0,1,2'd3,1,5'd30,32'd6,0,0,5'd0));
    step("to2_start", 1, 5'd0, 5'd7, 0, 0, 0, ev(1,1,1,0,2'd0,0,5'd0,32'd0,0,0,5'd7));
    for (int i = 0; i < 3; i++)
      step("to2_wait", 1, 5'd0, 5'd7, 0, 0, 0, ev(1,0,1,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("to2_rdy_last", 1, 5'd0, 5'd7, 0, 1, 0, ev(1,0,1,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("to2_wb", 0, 5'd0, 5'd0, 0, 0, 0, ev(0,0,1,1,2'd2,0,5'd0,32'd0,0,0,5'd0));
`else
    step("long_start", 1, 5'd0, 5'd6, 0, 0, 0, ev(1,1,0,0,2'd0,0,5'd0,32'd0,0,0,5'd6));
    for (int i = 0; i < 8; i++)
      step("long_wait", 1, 5'd0, 5'd6, 0, 0, 0, ev(1,0,0,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("long_rdy", 1, 5'd0, 5'd6, 0, 1, 0, ev(1,0,0,0,2'd0,0,5'd0,32'd0,0,0,5'd0));
    step("long_wb", 0, 5'd0, 5'd0, 0, 0, 0, ev(0,0,0,1,2'd2,0,5'd0,32'd0,0,0,5'd0));
`endif
    step("final_idle", 0, 5'd0, 5'd0, 0, 0, 0, Z);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
